// File: rtl/inv_mix_columns_iter.sv
// -----------------------------------------------------------------------------
// inv_mix_columns_iter
//
// Iterative AES InvMixColumns engine for the decryption datapath. A 128-bit
// state is accepted over a valid/ready handshake. The engine transforms
// COLS_PER_CYCLE columns per clock in place and then presents the result on a
// registered valid/ready output. It accepts no new state until the current
// result has been taken.
//
// Parameters:
//   COLS_PER_CYCLE  columns transformed per clock (1, 2 or 4)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   in_state is valid
//   in_ready   block can accept a state (high only in IDLE)
//   in_state   state, column c = bits [127-32c : 96-32c], a0 = column MSB byte
//   out_valid  out_state holds a finished result
//   out_ready  downstream accepts the result
//   out_state  InvMixColumns(in_state), same layout, registered
//   busy       high while columns are being transformed
// -----------------------------------------------------------------------------
module inv_mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_illegal_cols
            $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Index of the first column of the final group; reaching it means the
    // current cycle finishes the state.
    localparam int LAST_IDX = 4 - COLS_PER_CYCLE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [127:0]  work_reg;
    logic [127:0]  work_next;
    logic [127:0]  out_state_reg;
    logic          out_valid_reg;
    logic [1:0]    col_idx_reg;
    logic [1:0]    col_idx_next;
    logic          last_group;

    logic [6:0]    col_base [COLS_PER_CYCLE];
    logic [31:0]   col_in   [COLS_PER_CYCLE];
    logic [31:0]   col_out  [COLS_PER_CYCLE];

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the circulant (0e 0b 0d 09) matrix. The four
    // constants are assembled from the shared x2/x4/x8 chain of each byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a   [4];
        logic [7:0] x2  [4];
        logic [7:0] x4  [4];
        logic [7:0] x8  [4];
        logic [7:0] m09 [4];
        logic [7:0] m0b [4];
        logic [7:0] m0d [4];
        logic [7:0] m0e [4];
        logic [7:0] b   [4];
        for (int j = 0; j < 4; j++) begin
            a[j]   = col[31-8*j -: 8];
            x2[j]  = xtime(a[j]);
            x4[j]  = xtime(x2[j]);
            x8[j]  = xtime(x4[j]);
            m09[j] = x8[j] ^ a[j];
            m0b[j] = x8[j] ^ x2[j] ^ a[j];
            m0d[j] = x8[j] ^ x4[j] ^ a[j];
            m0e[j] = x8[j] ^ x4[j] ^ x2[j];
        end
        b[0] = m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3];
        b[1] = m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3];
        b[2] = m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3];
        b[3] = m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3];
        return {b[0], b[1], b[2], b[3]};
    endfunction

    // One transform lane per column handled in a cycle. Column c sits at
    // bit offset 32*(3-c); for a 2-bit index, 3-c is simply ~c.
    generate
        for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
            logic [1:0] idx;
            assign idx          = col_idx_reg + 2'(gi);
            assign col_base[gi] = {~idx, 5'b00000};
            assign col_in[gi]   = work_reg[col_base[gi] +: 32];
            assign col_out[gi]  = inv_mix_col(col_in[gi]);
        end
    endgenerate

    always_comb begin
        work_next = work_reg;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            work_next[col_base[i] +: 32] = col_out[i];
        end
    end

    assign last_group   = (col_idx_reg == 2'(LAST_IDX));
    // Advancing by 4 in a 2-bit counter leaves it at 0, so a single-group
    // engine never moves the index.
    assign col_idx_next = col_idx_reg + 2'(COLS_PER_CYCLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (last_group) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: working register, column counter and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            work_reg      <= '0;
            col_idx_reg   <= '0;
            out_state_reg <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        work_reg    <= in_state;
                        col_idx_reg <= '0;
                    end
                end
                BUSY: begin
                    work_reg    <= work_next;
                    col_idx_reg <= col_idx_next;
                    if (last_group) begin
                        out_state_reg <= work_next;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_state = out_state_reg;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// -----------------------------------------------------------------------------
// tb_inv_mix_columns_iter
//
// Drives three engines (COLS_PER_CYCLE = 1, 2, 4) from one clock and compares
// results with fixed AES vectors and with a plain GF(2^8) matrix model.
// -----------------------------------------------------------------------------
module tb_inv_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_state  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_state [3];
    logic         busy      [3];

    int checks = 0;
    int errors = 0;

    localparam int CPC [3] = '{1, 2, 4};

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            inv_mix_columns_iter #(.COLS_PER_CYCLE(CPC[gi])) dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid[gi]),
                .in_ready  (in_ready[gi]),
                .in_state  (in_state[gi]),
                .out_valid (out_valid[gi]),
                .out_ready (out_ready[gi]),
                .out_state (out_state[gi]),
                .busy      (busy[gi])
            );
        end
    endgenerate

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        logic       hi;
        a = a_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [7:0]   coef [4];
        logic [7:0]   a    [4];
        logic [7:0]   acc;
        logic [127:0] r;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[j], coef[(j - row + 4) % 4]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on engine k: accept, wait, hold for holdoff
    // cycles with out_ready low, then hand off.
    task automatic do_transaction(input int k, input logic [127:0] din,
                                  input logic [127:0] exp, input int holdoff,
                                  input string name);
        int n;
        checks++;
        if (in_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s[%0d] ready_before_accept got %b want 1", name, k, in_ready[k]);
        end
        in_state[k]  = din;
        in_valid[k]  = 1'b1;
        out_ready[k] = 1'b0;
        tick();
        in_valid[k] = 1'b0;
        in_state[k] = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        do begin
            tick();
            n++;
            if (out_valid[k] !== 1'b1) begin
                checks++;
                if (busy[k] !== 1'b1 || in_ready[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s[%0d] busy_phase got busy=%b in_ready=%b want 1/0",
                             name, k, busy[k], in_ready[k]);
                end
            end
        end while (out_valid[k] !== 1'b1 && n < 50);
        checks++;
        if (n != 4 / CPC[k]) begin
            errors++;
            $display("FAIL %s[%0d] latency got %0d want %0d", name, k, n, 4 / CPC[k]);
        end
        checks++;
        if (out_state[k] !== exp) begin
            errors++;
            $display("FAIL %s[%0d] result got %h want %h", name, k, out_state[k], exp);
        end
        for (int h = 0; h < holdoff; h++) begin
            tick();
            checks++;
            if (out_valid[k] !== 1'b1 || out_state[k] !== exp || in_ready[k] !== 1'b0 || busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL %s[%0d] hold got v=%b rdy=%b busy=%b %h want 1/0/0 %h",
                         name, k, out_valid[k], in_ready[k], busy[k], out_state[k], exp);
            end
        end
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
        checks++;
        if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s[%0d] handshake got v=%b rdy=%b want 0/1", name, k, out_valid[k], in_ready[k]);
        end
        $display("%s cpc=%0d in=%h out=%h latency=%0d hold=%0d", name, CPC[k], din, out_state[k], n, holdoff);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; in_state[k] = '0; out_ready[k] = 1'b1;
        end
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0 || out_state[k] !== 128'h0) begin
                errors++;
                $display("FAIL reset[%0d] got v=%b rdy=%b busy=%b %h want 0/1/0/0",
                         k, out_valid[k], in_ready[k], busy[k], out_state[k]);
            end
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (out_valid[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_idle_out_valid[%0d] got %b want 0", k, out_valid[k]);
                end
            end
        end
        for (int k = 0; k < 3; k++) out_ready[k] = 1'b0;
        $display("reset: idle outputs observed for 10 cycles");
    endtask

    task automatic test_reset_with_valid();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b1; in_state[k] = {4{32'hdeadbeef}};
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) in_valid[k] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy[k] !== 1'b0 || in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_wins[%0d] got busy=%b rdy=%b v=%b want 0/1/0",
                         k, busy[k], in_ready[k], out_valid[k]);
            end
        end
        $display("reset_with_valid: nothing captured");
    endtask

    task automatic test_reference();
        logic [127:0] din;
        logic [127:0] exp;
        din = {32'h8e4da1bc, 32'hd5d5d7d6, 32'h4d7ebdf8, 32'h01010101};
        exp = {32'hdb135345, 32'hd4d4d4d5, 32'h2d26314c, 32'h01010101};
        for (int k = 0; k < 3; k++) do_transaction(k, din, exp, 0, "reference");
    endtask

    task automatic test_backpressure();
        logic [127:0] din;
        logic [127:0] exp;
        din = {32'h9fdc589d, 32'hc6c6c6c6, 32'h01010101, 32'hd5d5d7d6};
        exp = {32'hf20a225c, 32'hc6c6c6c6, 32'h01010101, 32'hd4d4d4d5};
        for (int k = 0; k < 3; k++) do_transaction(k, din, exp, 5, "backpressure");
    endtask

    task automatic test_busy_reject();
        logic [127:0] a;
        logic [127:0] b;
        int n;
        for (int k = 0; k < 3; k++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            in_state[k] = a; in_valid[k] = 1'b1;
            tick();
            in_state[k] = b;   // held valid while the engine is occupied
            n = 0;
            while (out_valid[k] !== 1'b1 && n < 50) begin
                checks++;
                if (in_ready[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_reject_ready[%0d] got %b want 0", k, in_ready[k]);
                end
                tick();
                n++;
            end
            tick(); tick();
            checks++;
            if (out_valid[k] !== 1'b1 || out_state[k] !== model(a)) begin
                errors++;
                $display("FAIL busy_reject_first[%0d] got v=%b %h want 1 %h", k, out_valid[k], out_state[k], model(a));
            end
            out_ready[k] = 1'b1;
            tick();
            out_ready[k] = 1'b0;
            checks++;
            if (in_ready[k] !== 1'b1) begin
                errors++;
                $display("FAIL busy_reject_idle[%0d] got %b want 1", k, in_ready[k]);
            end
            tick();   // second state accepted here
            in_valid[k] = 1'b0;
            n = 0;
            while (out_valid[k] !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
            checks++;
            if (out_valid[k] !== 1'b1 || out_state[k] !== model(b)) begin
                errors++;
                $display("FAIL busy_reject_second[%0d] got v=%b %h want 1 %h", k, out_valid[k], out_state[k], model(b));
            end
            out_ready[k] = 1'b1;
            tick();
            out_ready[k] = 1'b0;
            $display("busy_reject cpc=%0d first=%h second=%h", CPC[k], a, b);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] din;
        din = {$urandom, $urandom, $urandom, $urandom};
        in_state[0] = din; in_valid[0] = 1'b1;
        tick();                 // accept edge
        in_valid[0] = 1'b0;
        tick();                 // end of first BUSY cycle
        rst = 1'b1;
        tick();                 // reset on second BUSY cycle
        rst = 1'b0;
        checks++;
        if (busy[0] !== 1'b0 || in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_state[0] !== 128'h0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b rdy=%b v=%b %h want 0/1/0/0",
                     busy[0], in_ready[0], out_valid[0], out_state[0]);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (out_valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_no_output got %b want 0", out_valid[0]);
            end
        end
        $display("reset_mid: abandoned %h", din);
        din = {$urandom, $urandom, $urandom, $urandom};
        do_transaction(0, din, model(din), 1, "after_reset");
    endtask

    task automatic test_random();
        logic [127:0] din;
        for (int t = 0; t < 12; t++) begin
            for (int k = 0; k < 3; k++) begin
                din = {$urandom, $urandom, $urandom, $urandom};
                do_transaction(k, din, model(din), int'($urandom_range(0, 3)), "random");
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] din;
        for (int t = 0; t < 4; t++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            do_transaction(t % 3, din, model(din), 0, "back_to_back");
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; in_state[k] = '0; out_ready[k] = 1'b0;
        end
        test_reset();
        test_reset_with_valid();
        test_reference();
        test_backpressure();
        test_busy_reject();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

endmodule
